// File: rtl/fetch_unit_pkg.sv
// codes: shared constants and fetch FSM state type for the RV32I front end
package codes;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/acknowledge bus
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  modport master (output imemReq, imemAddr, input imemAck, imemData);
  modport slave (input imemReq, imemAddr, output imemAck, imemData);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem handshake and registered instruction for the decoder
module fetch_unit
  import codes::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clock,
  input  logic               nReset,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirectPC,
  output logic               instrValid,
  output logic [31:0]        instr,
  output logic [31:0]        pc,
  output logic [31:0]        pcPlus4,
  output logic [4:0]         opcode,
  output logic [3:0]         ctrl,
  output logic               illegal,
  output logic               fault
);
  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic         req, ack;
  logic [31:0]  target;

  assign req = (state_q == FETCH) || (state_q == FLUSH) || (state_q == HOLD && !stall);
  assign ack = req && imem.imemAck;
  assign target = {redirectPC[31:2], 2'b00};

  // next state: capture on ack, FSM moves, then redirect overrides everything
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    fault_d      = fault_q | (redirect && redirectPC[1:0] != 2'b00);
    if (ack && state_q != FLUSH) begin
      instr_d    = imem.imemData;
      pc_d       = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      valid_d    = 1'b1;
    end
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: state_d = ack ? HOLD : FETCH;
      HOLD: begin
        if (!stall && !ack) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (ack) begin
          fetch_pc_d = pending_pc_q;
          state_d    = FETCH;
        end
      end
    endcase
    if (redirect) begin
      valid_d = 1'b0;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (req && !ack) begin
        pending_pc_d = target;
        fetch_pc_d   = fetch_pc_q;
        state_d      = FLUSH;
      end else begin
        fetch_pc_d = target;
        state_d    = FETCH;
      end
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem.imemReq  = req;
  assign imem.imemAddr = fetch_pc_q;
  assign instrValid    = valid_q;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign pcPlus4       = pc_q + 32'd4;
  assign opcode        = instr_q[6:2];
  assign ctrl          = {instr_q[30], instr_q[14:12]};
  assign illegal       = valid_q && instr_q[1:0] != 2'b11;
  assign fault         = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  import codes::*;
  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'h0;
  logic        instrValid, illegal, fault;
  logic [31:0] instr, pc, pcPlus4;
  logic [4:0]  opcode;
  logic [3:0]  ctrl;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        m_idle, m_valid, m_drop, m_fault, m_req;
  logic [31:0] m_pc, m_instr, m_next;
  logic        p_req, p_ack;
  logic [31:0] p_addr;

  always #5 clk = ~clk;

  fetch_unit_if imem();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h200) return 32'hFFFF_FFFC;
    return {a[31:2] ^ 30'h15F0_C3B7, a[5:4] | 2'b10};
  endfunction

  assign imem.imemData = mem_word(imem.imemAddr);

  fetch_unit dut (
    .clock(clk), .nReset(nReset), .imem(imem), .stall(stall),
    .redirect(redirect), .redirectPC(redirectPC), .instrValid(instrValid),
    .instr(instr), .pc(pc), .pcPlus4(pcPlus4), .opcode(opcode), .ctrl(ctrl),
    .illegal(illegal), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic n, input logic a, input logic s, input logic r, input logic [31:0] rp);
    @(posedge clk);
    #1;
    nReset = n;
    imem.imemAck = a;
    stall = s;
    redirect = r;
    redirectPC = rp;
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!nReset) begin
        m_idle = 1'b1; m_valid = 1'b0; m_drop = 1'b0; m_fault = 1'b0;
        m_pc = 32'h0; m_instr = NOP_INSTR; m_next = 32'h0;
        p_req = 1'b0; p_ack = 1'b0; p_addr = 32'h0;
      end else begin
        m_req = !m_idle && (!m_valid || !stall);
        check("m_req", 32'(imem.imemReq), 32'(m_req));
        check("m_valid", 32'(instrValid), 32'(m_valid));
        check("m_pc", pc, m_pc);
        check("m_instr", instr, m_instr);
        check("m_pc4", pcPlus4, m_pc + 32'd4);
        check("m_opcode", 32'(opcode), 32'(m_instr[6:2]));
        check("m_ctrl", 32'(ctrl), 32'({m_instr[30], m_instr[14:12]}));
        check("m_illegal", 32'(illegal), 32'(m_valid && m_instr[1:0] != 2'b11));
        check("m_fault", 32'(fault), 32'(m_fault));
        if (m_req && !m_drop) check("m_addr", imem.imemAddr, m_next);
        if (p_req && !p_ack) check("m_addr_hold", imem.imemAddr, p_addr);
        if (redirect) begin
          m_fault = m_fault | (redirectPC[1:0] != 2'b00);
          m_valid = 1'b0;
          m_drop = m_req && !imem.imemAck;
          m_next = {redirectPC[31:2], 2'b00};
        end else if (m_req && imem.imemAck) begin
          if (m_drop) m_drop = 1'b0;
          else begin
            m_pc = m_next;
            m_instr = mem_word(m_next);
            m_next = m_next + 32'd4;
            m_valid = 1'b1;
          end
        end else if (m_req) m_valid = 1'b0;
        m_idle = 1'b0;
        p_req = imem.imemReq;
        p_ack = imem.imemAck;
        p_addr = imem.imemAddr;
      end
    end
  end

  initial begin
    imem.imemAck = 1'b0;
    repeat (3) drive(0, 0, 0, 0, 0);
    check("rst_req", 32'(imem.imemReq), 0);
    check("rst_valid", 32'(instrValid), 0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc4", pcPlus4, 32'h4);
    check("rst_opcode", 32'(opcode), 32'h04);
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_fault", 32'(fault), 0);
    drive(1, 1, 0, 0, 0);
    check("c0_req", 32'(imem.imemReq), 0);
    drive(1, 1, 0, 0, 0);
    check("c1_req", 32'(imem.imemReq), 1);
    check("c1_addr", imem.imemAddr, 32'h0);
    drive(1, 1, 0, 0, 0);
    check("c2_valid", 32'(instrValid), 1);
    check("c2_pc", pc, 32'h0);
    check("c2_opcode", 32'(opcode), 32'h04);
    check("c2_ctrl", 32'(ctrl), 0);
    check("c2_pc4", pcPlus4, 32'h4);
    check("c2_addr", imem.imemAddr, 32'h4);
    drive(1, 1, 0, 0, 0);
    check("c3_addr", imem.imemAddr, 32'h8);
    check("c3_pc", pc, 32'h4);
    drive(1, 1, 0, 0, 0);
    check("c4_addr", imem.imemAddr, 32'hC);
    check("c4_valid", 32'(instrValid), 1);
    drive(1, 0, 0, 0, 0);
    check("c5_addr", imem.imemAddr, 32'h10);
    drive(1, 0, 0, 0, 0);
    check("c6_valid", 32'(instrValid), 0);
    check("c6_addr", imem.imemAddr, 32'h10);
    drive(1, 1, 0, 0, 0);
    check("c7_addr", imem.imemAddr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0);
      check("stall_req", 32'(imem.imemReq), 0);
      check("stall_pc", pc, 32'h10);
      check("stall_instr", instr, mem_word(32'h10));
    end
    drive(1, 0, 0, 0, 0);
    check("c11_addr", imem.imemAddr, 32'h14);
    drive(1, 0, 0, 1, 32'h100);
    check("c12_valid", 32'(instrValid), 0);
    drive(1, 0, 0, 0, 0);
    check("flush_addr", imem.imemAddr, 32'h14);
    check("flush_req", 32'(imem.imemReq), 1);
    drive(1, 1, 0, 0, 0);
    check("flush_ack_addr", imem.imemAddr, 32'h14);
    drive(1, 0, 0, 0, 0);
    check("redir_addr", imem.imemAddr, 32'h100);
    check("redir_valid", 32'(instrValid), 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 32'h102);
    check("redir_pc", pc, 32'h100);
    check("redir_valid2", 32'(instrValid), 1);
    drive(1, 1, 0, 0, 0);
    check("mis_addr", imem.imemAddr, 32'h100);
    check("mis_fault", 32'(fault), 1);
    drive(1, 0, 1, 1, 32'h200);
    drive(1, 1, 0, 0, 0);
    check("ill_addr", imem.imemAddr, 32'h200);
    drive(1, 0, 1, 1, 32'hFFFF_FFFC);
    check("ill_instr", instr, 32'hFFFF_FFFC);
    check("ill_illegal", 32'(illegal), 1);
    check("ill_ctrl", 32'(ctrl), 32'hF);
    check("ill_opcode", 32'(opcode), 32'h1F);
    check("ill_fault", 32'(fault), 1);
    drive(1, 1, 0, 0, 0);
    check("wrap_addr0", imem.imemAddr, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 0);
    check("wrap_addr1", imem.imemAddr, 32'h0);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pcPlus4, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      int k;
      t = {22'h0, 8'($urandom_range(255)), 2'b00};
      k = $urandom_range(39);
      if (k == 0) t = 32'hFFFF_FFF4;
      else if (k == 1) t[1:0] = 2'($urandom_range(3));
      drive(1, $urandom_range(9) < 6, $urandom_range(9) < 3, $urandom_range(99) < 7, t);
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("pre_rst_req", 32'(imem.imemReq), 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("mid_rst_req", 32'(imem.imemReq), 0);
    check("mid_rst_fault", 32'(fault), 0);
    check("mid_rst_valid", 32'(instrValid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
